// File: rtl/cgra_input_mem_node.sv
// cgra_input_mem_node: strided OBI-style memory reader feeding one CGRA input node through a credit-limited FIFO
//   clk_i, rst_i (async, active-high)
//   start_i, base_addr_i, stride_i, size_i : transfer request from the control FSM
//   req_o, addr_o, gnt_i, rvalid_i, rdata_i : memory read port
//   data_o, valid_o, ready_i              : fabric-side valid/ready stream
//   busy_o, done_o                        : status back to the control FSM
module cgra_input_mem_node #(
  parameter int DATA_WIDTH        = 32,
  parameter int ADDR_WIDTH        = 32,
  parameter int SIZE_WIDTH        = 16,
  parameter int FIFO_DEPTH        = 8,
  parameter int WORST_MEM_LATENCY = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [15:0]           stride_i,
  input  logic [SIZE_WIDTH-1:0] size_i,
  output logic                  req_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  input  logic                  gnt_i,
  input  logic                  rvalid_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic                  done_o
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  if (WORST_MEM_LATENCY < 1 || FIFO_DEPTH < 1) begin : g_param_check
    $error("cgra_input_mem_node: bad parameters");
  end
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           stride_q, stride_d;
  logic [SIZE_WIDTH-1:0] size_q, size_d, issued_q, issued_d, popped_q, popped_d;
  logic [CW-1:0]         count_q, count_d, outst_q, outst_d;
  logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic                  grant, push, pop;
  // buffered plus in-flight words never exceed the FIFO size, so every response has a slot
  assign req_o   = (state_q == FETCH) && (({1'b0, count_q} + {1'b0, outst_q}) < (CW+1)'(FIFO_DEPTH));
  assign addr_o  = addr_q;
  assign grant   = req_o & gnt_i;
  // responses arriving while idle are leftovers from before a reset
  assign push    = rvalid_i & (state_q != IDLE);
  assign valid_o = count_q != '0;
  assign pop     = valid_o & ready_i;
  assign data_o  = valid_o ? mem_q[rd_q] : '0;
  assign busy_o  = state_q != IDLE;
  assign done_o  = state_q == DONE;
  always_comb begin
    state_d  = state_q;
    stride_d = stride_q;
    size_d   = size_q;
    addr_d   = grant ? addr_q + ADDR_WIDTH'(stride_q) : addr_q;
    issued_d = issued_q + SIZE_WIDTH'(grant);
    popped_d = popped_q + SIZE_WIDTH'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    outst_d  = outst_q + CW'(grant) - CW'(push);
    wr_d     = push ? (wr_q == PW'(FIFO_DEPTH - 1) ? '0 : wr_q + PW'(1)) : wr_q;
    rd_d     = pop  ? (rd_q == PW'(FIFO_DEPTH - 1) ? '0 : rd_q + PW'(1)) : rd_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d  = (size_i != '0) ? FETCH : DONE;
        addr_d   = base_addr_i;
        stride_d = stride_i;
        size_d   = size_i;
        issued_d = '0;
        popped_d = '0;
      end
      FETCH:   state_d = (grant && issued_q + SIZE_WIDTH'(1) == size_q) ? DRAIN : FETCH;
      DRAIN:   state_d = (pop && popped_q + SIZE_WIDTH'(1) == size_q) ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      size_q   <= '0;
      issued_q <= '0;
      popped_q <= '0;
      count_q  <= '0;
      outst_q  <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      size_q   <= size_d;
      issued_q <= issued_d;
      popped_q <= popped_d;
      count_q  <= count_d;
      outst_q  <= outst_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= rdata_i;
  end
endmodule

// File: tb/tb_cgra_input_mem_node.sv
// tb_cgra_input_mem_node: randomized scoreboard bench for the strided memory reader
module tb_cgra_input_mem_node;
  localparam int D = 8;
  logic        clk_i = 0, rst_i = 1, start_i = 0, gnt_i = 0, rvalid_i = 0, ready_i = 0;
  logic [31:0] base_addr_i = 0, addr_o, rdata_i = 0, data_o;
  logic [15:0] stride_i = 0, size_i = 0;
  logic        req_o, valid_o, busy_o, done_o;
  int checks = 0, errors = 0, cyc = 0;
  int gnt_pct = 100, lat_min = 1, lat_max = 1, rdy_pct = 100, withhold = 0, grant_limit = 1 << 30;
  int grants = 0, rvalids = 0, inflight = 0, max_inflight = 0, addr_wait = 0;
  int start_cyc = 0, first_valid_cyc = -1, done_cyc = -1, done_cnt = 0, busy_cnt = 0, req_cnt = 0;
  logic        pend = 0;
  logic [31:0] pend_addr = 0, salt = 0;
  logic [31:0] exp_addr[$], exp_data[$], rd_q[$];
  int          due_q[$];

  cgra_input_mem_node dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
    .stride_i(stride_i), .size_i(size_i), .req_o(req_o), .addr_o(addr_o), .gnt_i(gnt_i),
    .rvalid_i(rvalid_i), .rdata_i(rdata_i), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mdata(input logic [31:0] a, input logic [31:0] s);
    return (a * 32'h9E3779B1) ^ s;
  endfunction

  // memory model: grants by policy, returns data in order after a random latency
  initial begin
    int last_due = 0;
    forever begin
      @(negedge clk_i);
      if (pend) begin
        chk("req_hold", req_o, 1);
        chk("addr_hold", addr_o, pend_addr);
      end
      rvalid_i = 0;
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        void'(due_q.pop_front());
        rdata_i  = rd_q.pop_front();
        rvalid_i = 1;
        rvalids++;
      end
      gnt_i = 0;
      pend  = 0;
      if (req_o) begin
        if (addr_wait >= withhold && grants < grant_limit && $urandom_range(99) < gnt_pct) begin
          int due;
          gnt_i = 1;
          addr_wait = 0;
          grants++;
          inflight++;
          if (inflight > max_inflight) max_inflight = inflight;
          chk("credit_limit", inflight <= D, 1);
          chk("grant_expected", exp_addr.size() > 0, 1);
          if (exp_addr.size() > 0) chk("addr", addr_o, exp_addr.pop_front());
          due = cyc + $urandom_range(lat_max, lat_min);
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          due_q.push_back(due);
          rd_q.push_back(mdata(addr_o, salt));
        end else begin
          addr_wait++;
          pend = 1;
          pend_addr = addr_o;
        end
      end
    end
  end

  // fabric model and output monitor
  initial begin
    forever begin
      @(negedge clk_i);
      ready_i = $urandom_range(99) < rdy_pct;
      if (valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (busy_o) busy_cnt++;
      if (req_o) req_cnt++;
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (valid_o && ready_i) begin
        inflight--;
        chk("pop_expected", exp_data.size() > 0, 1);
        if (exp_data.size() > 0) chk("data", data_o, exp_data.pop_front());
      end
    end
  end

  task automatic run_xfer(input logic [31:0] base, input logic [15:0] stride, input logic [15:0] size);
    logic [31:0] a;
    @(negedge clk_i);
    salt = $urandom;
    a = base;
    for (int i = 0; i < int'(size); i++) begin
      exp_addr.push_back(a);
      exp_data.push_back(mdata(a, salt));
      a = a + {16'b0, stride};
    end
    start_i = 1; base_addr_i = base; stride_i = stride; size_i = size;
    start_cyc = cyc; first_valid_cyc = -1; done_cyc = -1; done_cnt = 0; busy_cnt = 0; req_cnt = 0;
    @(negedge clk_i);
    start_i = 0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done_o && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    chk({name, "_done_seen"}, done_o, 1);
    @(negedge clk_i);
    chk({name, "_done_once"}, done_cnt, 1);
    chk({name, "_done_low"}, done_o, 0);
    chk({name, "_idle"}, busy_o, 0);
    chk({name, "_words_left"}, exp_data.size(), 0);
    chk({name, "_addrs_left"}, exp_addr.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, r0, n;
    #1;
    chk("rst_req", req_o, 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    repeat (2) @(negedge clk_i);
    rst_i = 0;
    // 1: immediate memory, always-ready fabric, latency start->valid_o of 3
    run_xfer(32'h100, 16'd4, 16'd4);
    wait_done("t1", 40);
    chk("t1_first_valid_latency", first_valid_cyc - start_cyc, 3);
    // 4: empty transfer
    run_xfer(32'h500, 16'd4, 16'd0);
    wait_done("t4", 10);
    chk("t4_no_req", req_cnt, 0);
    chk("t4_busy_cycles", busy_cnt, 1);
    chk("t4_done_delay_ok", (done_cyc - start_cyc) inside {[1:2]}, 1);
    // 2: stalled fabric fills exactly the credit window
    rdy_pct = 0; lat_min = 1; lat_max = 4;
    g0 = grants;
    max_inflight = 0;
    run_xfer(32'h2000, 16'd4, 16'd20);
    repeat (30) @(negedge clk_i);
    chk("t2_grants_when_stalled", grants - g0, 8);
    chk("t2_req_low_when_full", req_o, 0);
    rdy_pct = 70;
    wait_done("t2", 400);
    chk("t2_max_inflight", max_inflight <= D, 1);
    // 3: grants withheld, long latency
    rdy_pct = 100; withhold = 3; lat_min = 4; lat_max = 4;
    run_xfer(32'h3000, 16'd12, 16'd6);
    wait_done("t3", 200);
    withhold = 0;
    // 5: address wrap, plus an ignored mid-transfer start
    gnt_pct = 60; lat_min = 1; lat_max = 4; rdy_pct = 60;
    run_xfer(32'hFFFF_FFF8, 16'd8, 16'd3);
    start_i = 1; base_addr_i = 32'h5000; stride_i = 16'd4; size_i = 16'd9;
    @(negedge clk_i);
    start_i = 0;
    wait_done("t5", 200);
    // randomized transfers
    for (int k = 0; k < 6; k++) begin
      gnt_pct = $urandom_range(100, 30); rdy_pct = $urandom_range(100, 20);
      lat_min = $urandom_range(2, 1); lat_max = $urandom_range(4, lat_min);
      withhold = $urandom_range(2);
      run_xfer($urandom, 16'($urandom), 16'($urandom_range(24, 1)));
      wait_done("rand", 1500);
    end
    withhold = 0;
    // 6: reset with words in flight and buffered; late responses must be dropped
    gnt_pct = 100; rdy_pct = 0; lat_min = 3; lat_max = 3;
    grant_limit = grants + 5;
    r0 = rvalids;
    run_xfer(32'h6000, 16'd4, 16'd10);
    n = 0;
    while (rvalids - r0 < 3 && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    chk("t6_three_returned", rvalids - r0 >= 3, 1);
    @(posedge clk_i);
    #1;
    rst_i = 1; pend = 0; addr_wait = 0;
    #1;
    chk("t6_rst_req", req_o, 0);
    chk("t6_rst_addr", addr_o, 0);
    chk("t6_rst_valid", valid_o, 0);
    chk("t6_rst_data", data_o, 0);
    chk("t6_rst_busy", busy_o, 0);
    chk("t6_rst_done", done_o, 0);
    exp_addr.delete(); exp_data.delete(); inflight = 0;
    @(negedge clk_i);
    rst_i = 0;
    n = 0;
    while (due_q.size() > 0 && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    repeat (2) @(negedge clk_i);
    chk("t6_late_rvalids", rvalids - r0, 5);
    chk("t6_late_dropped_valid", valid_o, 0);
    chk("t6_late_dropped_busy", busy_o, 0);
    grant_limit = 1 << 30; rdy_pct = 100; lat_min = 1; lat_max = 2;
    run_xfer(32'h7000, 16'd16, 16'd5);
    wait_done("t6_clean", 100);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
